sprite_motion_engine: RTL and testbench

Parametrised successor to the single-sprite bouncing mover in the demo video path. It owns one sprite's position in a scaled-down playfield and advances it once per N frames by a programmable step per axis. Each axis either bounces off the playfield edges, clamping at the edge, or wraps around. New positions load through a valid/ready port that is applied only at frame boundaries, so the picture never tears. It sits between the frame timing generator, which provides `next_frame`, and the sprite renderer, which consumes `sprite_x`/`sprite_y`.

---
 rtl/sprite_motion_engine.sv | 156 +++++++++++++++
 tb/tb_sprite_motion_engine.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sprite_motion_engine.sv
// sprite_motion_engine: per-frame sprite mover with bounce/wrap edges, frame-synchronous buffered load and serial shift-in
module sprite_motion_engine #(
    parameter int POS_WIDTH  = 8,
    parameter int AREA_W     = 160,
    parameter int AREA_H     = 120,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int DIV_WIDTH  = 4,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_movement,
    input  logic                  next_frame,
    input  logic [DIV_WIDTH-1:0]  frame_div,
    input  logic [STEP_WIDTH-1:0] step_x,
    input  logic [STEP_WIDTH-1:0] step_y,
    input  logic                  wrap_mode,
    input  logic                  shift_x,
    input  logic                  data_in_x,
    input  logic                  shift_y,
    input  logic                  data_in_y,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [POS_WIDTH-1:0]  load_x,
    input  logic [POS_WIDTH-1:0]  load_y,
    input  logic                  load_dir_x,
    input  logic                  load_dir_y,
    output logic [POS_WIDTH-1:0]  sprite_x,
    output logic [POS_WIDTH-1:0]  sprite_y,
    output logic                  dir_x,
    output logic                  dir_y,
    output logic                  hit_x,
    output logic                  hit_y,
    output logic                  moved
);
    localparam int MAX_X = AREA_W - SPRITE_W;
    localparam int MAX_Y = AREA_H - SPRITE_H;
    localparam logic [POS_WIDTH:0] MAX_XV = (POS_WIDTH+1)'(MAX_X);
    localparam logic [POS_WIDTH:0] MAX_YV = (POS_WIDTH+1)'(MAX_Y);

    if (MAX_X <= 0 || MAX_Y <= 0 || MAX_X >= (1 << POS_WIDTH) || MAX_Y >= (1 << POS_WIDTH) || STEP_WIDTH > POS_WIDTH) begin : g_bad_params
        $error("sprite_motion_engine: playfield range must be positive and fit in POS_WIDTH");
    end

    // Returns {hit, dir, pos} for one axis advanced by one move.
    function automatic logic [POS_WIDTH+1:0] advance(
        input logic [POS_WIDTH-1:0]  pos,
        input logic                  dir,
        input logic [STEP_WIDTH-1:0] step_in,
        input logic                  wrap,
        input logic [POS_WIDTH:0]    max
    );
        logic [POS_WIDTH:0] p, s, sum, res;
        logic nd, h;
        p   = {1'b0, pos};
        s   = (POS_WIDTH+1)'(step_in);
        s   = (s > max) ? max : s;
        sum = p + s;
        res = p;
        nd  = dir;
        h   = 1'b0;
        if (s != '0) begin
            if (!wrap && !dir) begin
                h   = (sum >= max);
                res = h ? max : sum;
                nd  = h;
            end else if (!wrap) begin
                h   = (p <= s);
                res = h ? '0 : p - s;
                nd  = !h;
            end else if (!dir) begin
                h   = (sum > max);
                res = sum % (max + 1'b1);
            end else begin
                h   = (p < s);
                res = h ? p + max + 1'b1 - s : p - s;
            end
        end
        return {h, nd, res[POS_WIDTH-1:0]};
    endfunction

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [POS_WIDTH-1:0] buf_x_q, buf_x_d, buf_y_q, buf_y_d;
    logic                 buf_dir_x_q, buf_dir_x_d, buf_dir_y_q, buf_dir_y_d;
    logic [POS_WIDTH-1:0] sprite_x_q, sprite_x_d, sprite_y_q, sprite_y_d;
    logic                 dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic                 hit_x_q, hit_x_d, hit_y_q, hit_y_d, moved_q, moved_d;
    logic                 slot, apply, move, accept;
    logic [POS_WIDTH+1:0] nx, ny;

    assign load_ready = !reset && !buf_valid_q;

    always_comb begin
        slot        = next_frame && (div_cnt_q >= frame_div);
        apply       = next_frame && buf_valid_q;
        move        = slot && enable_movement && !buf_valid_q;
        accept      = load_valid && load_ready;
        div_cnt_d   = next_frame ? (slot ? '0 : div_cnt_q + 1'b1) : div_cnt_q;
        buf_valid_d = accept ? 1'b1 : (apply ? 1'b0 : buf_valid_q);
        buf_x_d     = accept ? load_x : buf_x_q;
        buf_y_d     = accept ? load_y : buf_y_q;
        buf_dir_x_d = accept ? load_dir_x : buf_dir_x_q;
        buf_dir_y_d = accept ? load_dir_y : buf_dir_y_q;
        nx          = advance(sprite_x_q, dir_x_q, step_x, wrap_mode, MAX_XV);
        ny          = advance(sprite_y_q, dir_y_q, step_y, wrap_mode, MAX_YV);
        sprite_x_d  = shift_x ? {sprite_x_q[POS_WIDTH-2:0], data_in_x} : apply ? buf_x_q : move ? nx[POS_WIDTH-1:0] : sprite_x_q;
        sprite_y_d  = shift_y ? {sprite_y_q[POS_WIDTH-2:0], data_in_y} : apply ? buf_y_q : move ? ny[POS_WIDTH-1:0] : sprite_y_q;
        dir_x_d     = shift_x ? dir_x_q : apply ? buf_dir_x_q : move ? nx[POS_WIDTH] : dir_x_q;
        dir_y_d     = shift_y ? dir_y_q : apply ? buf_dir_y_q : move ? ny[POS_WIDTH] : dir_y_q;
        hit_x_d     = !shift_x && move && nx[POS_WIDTH+1];
        hit_y_d     = !shift_y && move && ny[POS_WIDTH+1];
        moved_d     = move;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_x_q     <= '0;
            buf_y_q     <= '0;
            buf_dir_x_q <= 1'b0;
            buf_dir_y_q <= 1'b0;
            sprite_x_q  <= '0;
            sprite_y_q  <= '0;
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            hit_x_q     <= 1'b0;
            hit_y_q     <= 1'b0;
            moved_q     <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_x_q     <= buf_x_d;
            buf_y_q     <= buf_y_d;
            buf_dir_x_q <= buf_dir_x_d;
            buf_dir_y_q <= buf_dir_y_d;
            sprite_x_q  <= sprite_x_d;
            sprite_y_q  <= sprite_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
            moved_q     <= moved_d;
        end
    end

    assign sprite_x = sprite_x_q;
    assign sprite_y = sprite_y_q;
    assign dir_x    = dir_x_q;
    assign dir_y    = dir_y_q;
    assign hit_x    = hit_x_q;
    assign hit_y    = hit_y_q;
    assign moved    = moved_q;
endmodule

// File: tb/tb_sprite_motion_engine.sv
// tb_sprite_motion_engine: cycle-by-cycle vector table plus handshake and mid-run reset sequences
module tb_sprite_motion_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_movement = 1'b0, next_frame = 1'b0, wrap_mode = 1'b0;
    logic [3:0] frame_div = '0, step_x = '0, step_y = '0;
    logic       shift_x = 1'b0, data_in_x = 1'b0, shift_y = 1'b0, data_in_y = 1'b0;
    logic       load_valid = 1'b0, load_ready;
    logic [7:0] load_x = '0, load_y = '0;
    logic       load_dir_x = 1'b0, load_dir_y = 1'b0;
    logic [7:0] sprite_x, sprite_y;
    logic       dir_x, dir_y, hit_x, hit_y, moved;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int nf, en, fd, sx, sy, wr, lv, lx, ly, ldx, ldy, shx, dix, shy, diy;
        int ex, ey, edx, edy, ehx, ehy, emv, erdy;
    } vec_t;

    vec_t tbl[33];

    sprite_motion_engine dut (
        .clk(clk), .reset(reset), .enable_movement(enable_movement), .next_frame(next_frame),
        .frame_div(frame_div), .step_x(step_x), .step_y(step_y), .wrap_mode(wrap_mode),
        .shift_x(shift_x), .data_in_x(data_in_x), .shift_y(shift_y), .data_in_y(data_in_y),
        .load_valid(load_valid), .load_ready(load_ready), .load_x(load_x), .load_y(load_y),
        .load_dir_x(load_dir_x), .load_dir_y(load_dir_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .dir_x(dir_x), .dir_y(dir_y), .hit_x(hit_x), .hit_y(hit_y), .moved(moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        next_frame      = 1'(t.nf);
        enable_movement = 1'(t.en);
        frame_div       = 4'(t.fd);
        step_x          = 4'(t.sx);
        step_y          = 4'(t.sy);
        wrap_mode       = 1'(t.wr);
        load_valid      = 1'(t.lv);
        load_x          = 8'(t.lx);
        load_y          = 8'(t.ly);
        load_dir_x      = 1'(t.ldx);
        load_dir_y      = 1'(t.ldy);
        shift_x         = 1'(t.shx);
        data_in_x       = 1'(t.dix);
        shift_y         = 1'(t.shy);
        data_in_y       = 1'(t.diy);
    endtask

    task automatic check_out(input string tag, input vec_t t);
        chk({tag, " sprite_x"}, int'(sprite_x), t.ex);
        chk({tag, " sprite_y"}, int'(sprite_y), t.ey);
        chk({tag, " dir_x"}, int'(dir_x), t.edx);
        chk({tag, " dir_y"}, int'(dir_y), t.edy);
        chk({tag, " hit_x"}, int'(hit_x), t.ehx);
        chk({tag, " hit_y"}, int'(hit_y), t.ehy);
        chk({tag, " moved"}, int'(moved), t.emv);
        chk({tag, " load_ready"}, int'(load_ready), t.erdy);
    endtask

    task automatic run(input string tag, input vec_t t);
        drive(t);
        @(posedge clk);
        #1;
        check_out(tag, t);
    endtask

    initial begin
        // nf en fd sx sy wr lv lx ly ldx ldy shx dix shy diy | ex ey edx edy ehx ehy emv erdy
        tbl[0]  = '{1,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   0,  0,0,0, 0,0,0,1};
        tbl[1]  = '{0,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   0,  0,0,0, 0,0,0,1};
        tbl[2]  = '{1,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   1,  1,0,0, 0,0,1,1};
        tbl[3]  = '{0,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   1,  1,0,0, 0,0,0,1};
        tbl[4]  = '{1,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   1,  1,0,0, 0,0,0,1};
        tbl[5]  = '{1,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   2,  2,0,0, 0,0,1,1};
        tbl[6]  = '{0,1,0,3,0,0, 1,126,5,0,0, 0,0,0,0, 2,  2,0,0, 0,0,0,0};
        tbl[7]  = '{1,1,0,3,0,0, 0,0,0,0,0, 0,0,0,0,   126,5,0,0, 0,0,0,1};
        tbl[8]  = '{1,1,0,3,0,0, 0,0,0,0,0, 0,0,0,0,   128,5,1,0, 1,0,1,1};
        tbl[9]  = '{1,1,0,3,0,0, 0,0,0,0,0, 0,0,0,0,   125,5,1,0, 0,0,1,1};
        tbl[10] = '{0,1,0,3,0,0, 0,0,0,0,0, 0,0,0,0,   125,5,1,0, 0,0,0,1};
        tbl[11] = '{0,1,0,3,0,1, 1,127,5,0,0, 0,0,0,0, 125,5,1,0, 0,0,0,0};
        tbl[12] = '{1,1,0,3,0,1, 0,0,0,0,0, 0,0,0,0,   127,5,0,0, 0,0,0,1};
        tbl[13] = '{1,1,0,3,0,1, 0,0,0,0,0, 0,0,0,0,   1,  5,0,0, 1,0,1,1};
        tbl[14] = '{0,1,0,3,0,1, 1,1,5,1,0, 0,0,0,0,   1,  5,0,0, 0,0,0,0};
        tbl[15] = '{1,1,0,3,0,1, 0,0,0,0,0, 0,0,0,0,   1,  5,1,0, 0,0,0,1};
        tbl[16] = '{1,1,0,3,0,1, 0,0,0,0,0, 0,0,0,0,   127,5,1,0, 1,0,1,1};
        tbl[17] = '{0,1,0,1,2,0, 1,4,10,0,0, 0,0,0,0,  127,5,1,0, 0,0,0,0};
        tbl[18] = '{1,1,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   4, 10,0,0, 0,0,0,1};
        tbl[19] = '{1,1,0,1,2,0, 0,0,0,0,0, 1,1,0,0,   9, 12,0,0, 0,0,1,1};
        tbl[20] = '{1,0,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   9, 12,0,0, 0,0,0,1};
        tbl[21] = '{0,1,0,1,2,0, 1,9,1,0,1, 0,0,0,0,   9, 12,0,0, 0,0,0,0};
        tbl[22] = '{1,1,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   9,  1,0,1, 0,0,0,1};
        tbl[23] = '{1,1,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   10, 0,0,0, 0,1,1,1};
        tbl[24] = '{0,1,0,1,2,0, 1,10,87,0,0, 0,0,0,0, 10, 0,0,0, 0,0,0,0};
        tbl[25] = '{1,1,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   10,87,0,0, 0,0,0,1};
        tbl[26] = '{1,1,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   11,88,0,1, 0,1,1,1};
        tbl[27] = '{0,1,0,1,2,0, 1,200,88,0,1, 0,0,0,0, 11,88,0,1, 0,0,0,0};
        tbl[28] = '{1,1,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   200,88,0,1, 0,0,0,1};
        tbl[29] = '{1,1,0,1,2,0, 0,0,0,0,0, 0,0,0,0,   128,86,1,1, 1,0,1,1};
        tbl[30] = '{0,1,0,1,2,0, 0,0,0,0,0, 0,0,1,0,   128,172,1,1, 0,0,0,1};
        tbl[31] = '{1,1,0,1,0,0, 1,20,30,0,0, 0,0,0,0, 127,172,1,1, 0,0,1,0};
        tbl[32] = '{1,1,0,1,0,0, 0,0,0,0,0, 0,0,0,0,   20,30,0,0, 0,0,0,1};

        repeat (3) begin
            @(posedge clk);
            #1;
            check_out("reset", '{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_reset", '{0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1});

        for (int i = 0; i < 33; i++) run($sformatf("vec%0d", i), tbl[i]);

        // Held load_valid: first value captured, second waits until ready returns.
        run("hs_accept", '{0,1,0,1,1,0, 1,50,40,0,0, 0,0,0,0, 20,30,0,0, 0,0,0,0});
        run("hs_hold1",  '{0,1,0,1,1,0, 1,60,60,0,0, 0,0,0,0, 20,30,0,0, 0,0,0,0});
        run("hs_hold2",  '{0,1,0,1,1,0, 1,60,60,0,0, 0,0,0,0, 20,30,0,0, 0,0,0,0});
        run("hs_apply",  '{1,1,0,1,1,0, 1,60,60,0,0, 0,0,0,0, 50,40,0,0, 0,0,0,1});
        run("hs_second", '{0,1,0,1,1,0, 1,60,60,0,0, 0,0,0,0, 50,40,0,0, 0,0,0,0});
        run("hs_apply2", '{1,1,0,1,1,0, 0,0,0,0,0, 0,0,0,0,   60,60,0,0, 0,0,0,1});

        // Reset mid-run drops the pending load and the divider count.
        run("mr_div",    '{1,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   60,60,0,0, 0,0,0,1});
        run("mr_load",   '{0,1,1,1,1,0, 1,99,99,0,0, 0,0,0,0, 60,60,0,0, 0,0,0,0});
        drive('{0,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_out("mr_reset", '{0,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0});
        reset = 1'b0;
        run("mr_frame1", '{1,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   0,0,0,0, 0,0,0,1});
        run("mr_frame2", '{1,1,1,1,1,0, 0,0,0,0,0, 0,0,0,0,   1,1,0,0, 0,0,1,1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
